// File: rtl/ecc_seq_pkg.sv
// Shared opcodes, width codes, error codes, FSM encoding and width-to-mask helper
// for the ECC operation sequencer.
package ecc_seq_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned WID_W = 2;
    localparam int unsigned ERR_W = 2;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_ENC  = 2'b00;
    localparam opcode_t OP_DEC  = 2'b01;
    localparam opcode_t OP_FULL = 2'b10;
    localparam opcode_t OP_RSVD = 2'b11;

    localparam logic [WID_W-1:0] WID_8  = 2'b00;
    localparam logic [WID_W-1:0] WID_16 = 2'b01;

    localparam logic [ERR_W-1:0] ERR_NONE   = 2'd0;
    localparam logic [ERR_W-1:0] ERR_UNCORR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC_GO,
        S_ENC_WAIT,
        S_DEC_GO,
        S_DEC_WAIT,
        S_FINISH
    } state_t;

    // Codes 10 and 11 both select the full 32-bit word.
    function automatic logic [31:0] width_to_mask(input logic [WID_W-1:0] w);
        case (w)
            WID_8:   return 32'h0000_00FF;
            WID_16:  return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ecc_width_mask.sv
// Combinational codeword-width mask generator shared by all masked datapaths.
module ecc_width_mask
    import ecc_seq_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [WID_W-1:0] width_i,
    output logic [W-1:0]     mask_o
);

    // Narrow widths are zero-extended; full width covers the whole bus.
    always_comb begin
        mask_o = '1;
        if (width_i == WID_8 || width_i == WID_16) begin
            mask_o = W'(width_to_mask(width_i));
        end
    end

endmodule

// File: rtl/ecc_op_sequencer.sv
// Sequences encode / decode / full-channel operations against the ECC engines.
// Optional engine-wait timeout is enabled by defining ECC_SEQ_TIMEOUT_EN.
module ecc_op_sequencer
    import ecc_seq_pkg::*;
#(
`ifdef ECC_SEQ_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 64,
`endif
    parameter int unsigned AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_wr,
    input  logic [OP_W-1:0]      ctrl,
    input  logic [AMBA_WORD-1:0] data_in,
    input  logic [WID_W-1:0]     codeword_width,
    input  logic [AMBA_WORD-1:0] noise,
    output logic                 enc_start,
    output logic [AMBA_WORD-1:0] enc_data,
    input  logic                 enc_done,
    input  logic [AMBA_WORD-1:0] enc_codeword,
    output logic                 dec_start,
    output logic [AMBA_WORD-1:0] dec_data,
    input  logic                 dec_done,
    input  logic [AMBA_WORD-1:0] dec_data_out,
    input  logic [ERR_W-1:0]     dec_num_err,
    output logic [WID_W-1:0]     width_sel,
    output logic                 busy,
    output logic                 op_done,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [ERR_W-1:0]     num_of_errors,
`ifdef ECC_SEQ_TIMEOUT_EN
    output logic                 timeout,
`endif
    output logic                 overrun
);

    state_t               state_q, state_d;
    opcode_t              op_q, op_d;
    logic [WID_W-1:0]     width_q, width_d;
    logic [AMBA_WORD-1:0] snap_data_q, snap_data_d;
    logic [AMBA_WORD-1:0] snap_noise_q, snap_noise_d;
    logic [AMBA_WORD-1:0] dec_opnd_q, dec_opnd_d;
    logic [AMBA_WORD-1:0] data_out_q, data_out_d;
    logic [ERR_W-1:0]     nerr_q, nerr_d;
    logic                 busy_q, busy_d;
    logic                 op_done_q, op_done_d;
    logic                 enc_start_q, enc_start_d;
    logic                 dec_start_q, dec_start_d;
    logic                 overrun_q, overrun_d;

`ifdef ECC_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    logic [WID_W-1:0]     mask_sel;
    logic [AMBA_WORD-1:0] mask;

    // In IDLE the live width is used so the launch-cycle snapshot is already masked.
    assign mask_sel = (state_q == S_IDLE) ? codeword_width : width_q;

    ecc_width_mask #(.W(AMBA_WORD)) u_mask (
        .width_i (mask_sel),
        .mask_o  (mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_ENC;
            width_q      <= '0;
            snap_data_q  <= '0;
            snap_noise_q <= '0;
            dec_opnd_q   <= '0;
            data_out_q   <= '0;
            nerr_q       <= '0;
            busy_q       <= 1'b0;
            op_done_q    <= 1'b0;
            enc_start_q  <= 1'b0;
            dec_start_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef ECC_SEQ_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            width_q      <= width_d;
            snap_data_q  <= snap_data_d;
            snap_noise_q <= snap_noise_d;
            dec_opnd_q   <= dec_opnd_d;
            data_out_q   <= data_out_d;
            nerr_q       <= nerr_d;
            busy_q       <= busy_d;
            op_done_q    <= op_done_d;
            enc_start_q  <= enc_start_d;
            dec_start_q  <= dec_start_d;
            overrun_q    <= overrun_d;
`ifdef ECC_SEQ_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        width_d      = width_q;
        snap_data_d  = snap_data_q;
        snap_noise_d = snap_noise_q;
        dec_opnd_d   = dec_opnd_q;
        data_out_d   = data_out_q;
        nerr_d       = nerr_q;
        overrun_d    = overrun_q;
`ifdef ECC_SEQ_TIMEOUT_EN
        timeout_d    = timeout_q;
        tmo_cnt_d    = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (ctrl_wr) begin
                    if (ctrl != OP_RSVD) begin
                        op_d         = ctrl;
                        width_d      = codeword_width;
                        snap_data_d  = data_in & mask;
                        snap_noise_d = noise;
                        dec_opnd_d   = data_in & mask;
                        overrun_d    = 1'b0;
`ifdef ECC_SEQ_TIMEOUT_EN
                        timeout_d    = 1'b0;
`endif
                        state_d      = (ctrl == OP_DEC) ? S_DEC_GO : S_ENC_GO;
                    end else begin
                        data_out_d = '0;
                        nerr_d     = ERR_UNCORR;
                        state_d    = S_FINISH;
                    end
                end
            end
            S_ENC_GO: state_d = S_ENC_WAIT;
            S_ENC_WAIT: begin
                if (enc_done) begin
                    if (op_q == OP_FULL) begin
                        dec_opnd_d = (enc_codeword ^ snap_noise_q) & mask;
                        state_d    = S_DEC_GO;
                    end else begin
                        data_out_d = enc_codeword & mask;
                        nerr_d     = ERR_NONE;
                        state_d    = S_FINISH;
                    end
                end
`ifdef ECC_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    data_out_d = '0;
                    nerr_d     = ERR_UNCORR;
                    timeout_d  = 1'b1;
                    state_d    = S_FINISH;
                end
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
            end
            S_DEC_GO: state_d = S_DEC_WAIT;
            S_DEC_WAIT: begin
                if (dec_done) begin
                    data_out_d = dec_data_out & mask;
                    nerr_d     = dec_num_err;
                    state_d    = S_FINISH;
                end
`ifdef ECC_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    data_out_d = '0;
                    nerr_d     = ERR_UNCORR;
                    timeout_d  = 1'b1;
                    state_d    = S_FINISH;
                end
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Any write outside IDLE (including FINISH) is dropped and flagged.
        if (ctrl_wr && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        // Pulses and busy are decoded from the next state so they line up with it.
        enc_start_d = (state_d == S_ENC_GO);
        dec_start_d = (state_d == S_DEC_GO);
        op_done_d   = (state_d == S_FINISH);
        busy_d      = (state_d == S_ENC_GO) || (state_d == S_ENC_WAIT) ||
                      (state_d == S_DEC_GO) || (state_d == S_DEC_WAIT);
    end

    assign enc_start     = enc_start_q;
    assign enc_data      = snap_data_q;
    assign dec_start     = dec_start_q;
    assign dec_data      = dec_opnd_q;
    assign width_sel     = width_q;
    assign busy          = busy_q;
    assign op_done       = op_done_q;
    assign data_out      = data_out_q;
    assign num_of_errors = nerr_q;
    assign overrun       = overrun_q;
`ifdef ECC_SEQ_TIMEOUT_EN
    assign timeout       = timeout_q;
`endif

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Scoreboard bench for ecc_op_sequencer: directed operations push expected results,
// a negedge monitor pops and compares on every op_done.
module tb_ecc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_wr;
    logic [1:0]  ctrl;
    logic [31:0] data_in;
    logic [1:0]  codeword_width;
    logic [31:0] noise;
    logic        enc_start;
    logic [31:0] enc_data;
    logic        enc_done;
    logic [31:0] enc_codeword;
    logic        dec_start;
    logic [31:0] dec_data;
    logic        dec_done;
    logic [31:0] dec_data_out;
    logic [1:0]  dec_num_err;
    logic [1:0]  width_sel;
    logic        busy;
    logic        op_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        overrun;
`ifdef ECC_SEQ_TIMEOUT_EN
    logic        timeout;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  nerr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ecc_op_sequencer #(
`ifdef ECC_SEQ_TIMEOUT_EN
        .TIMEOUT_CYCLES (8),
`endif
        .AMBA_WORD      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_wr        (ctrl_wr),
        .ctrl           (ctrl),
        .data_in        (data_in),
        .codeword_width (codeword_width),
        .noise          (noise),
        .enc_start      (enc_start),
        .enc_data       (enc_data),
        .enc_done       (enc_done),
        .enc_codeword   (enc_codeword),
        .dec_start      (dec_start),
        .dec_data       (dec_data),
        .dec_done       (dec_done),
        .dec_data_out   (dec_data_out),
        .dec_num_err    (dec_num_err),
        .width_sel      (width_sel),
        .busy           (busy),
        .op_done        (op_done),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
`ifdef ECC_SEQ_TIMEOUT_EN
        .timeout        (timeout),
`endif
        .overrun        (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds ctrl_wr for one cycle T; returns at T+1 (1 time unit after the edge).
    task automatic launch(input logic [1:0] op, input logic [31:0] d,
                          input logic [1:0] w, input logic [31:0] n);
        ctrl_wr        = 1'b1;
        ctrl           = op;
        data_in        = d;
        codeword_width = w;
        noise          = n;
        tick();
        ctrl_wr = 1'b0;
    endtask

    // Result monitor: every op_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && op_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL op_done_unexpected: got op_done=1 expected none (data_out=0x%0h) at %0t",
                         data_out, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_data_out", data_out, e.data);
                check("sb_num_err", 32'(num_of_errors), 32'(e.nerr));
            end
        end
    end

    initial begin
        rst = 1'b0; ctrl_wr = 1'b0; ctrl = 2'b00; data_in = '0; codeword_width = '0;
        noise = '0; enc_done = 1'b0; enc_codeword = '0; dec_done = 1'b0;
        dec_data_out = '0; dec_num_err = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_op_done", 32'(op_done), 0);
        check("rst_enc_start", 32'(enc_start), 0);
        check("rst_data_out", data_out, 0);
        check("rst_overrun", 32'(overrun), 0);
        rst = 1'b1;
        tick();

        // Encode, 8-bit: encoder answers two cycles after ENC_WAIT entry.
        exp_q.push_back('{data: 32'h0000_00A5, nerr: 2'd0});
        launch(2'b00, 32'h0000_00A5, 2'b00, 32'h0);
        check("enc8_enc_start", 32'(enc_start), 1);
        check("enc8_enc_data", enc_data, 32'hA5);
        check("enc8_busy_t1", 32'(busy), 1);
        tick();
        check("enc8_enc_start_once", 32'(enc_start), 0);
        tick();
        enc_done = 1'b1; enc_codeword = 32'h0000_01A5;
        tick();
        enc_done = 1'b0;
        check("enc8_op_done", 32'(op_done), 1);
        check("enc8_busy_done", 32'(busy), 0);
        tick();
        check("enc8_op_done_single", 32'(op_done), 0);

        // Full channel, 16-bit, noise flips bit 2; stray dec_done in ENC_WAIT is ignored.
        exp_q.push_back('{data: 32'h0000_1234, nerr: 2'd1});
        launch(2'b10, 32'h0001_1234, 2'b01, 32'h0000_0004);
        check("full_enc_data", enc_data, 32'h1234);
        check("full_width_sel", 32'(width_sel), 1);
        tick();
        enc_done = 1'b1; enc_codeword = 32'h0003_1234;
        dec_done = 1'b1; dec_data_out = 32'hFFFF_FFFF; dec_num_err = 2'd2;
        tick();
        enc_done = 1'b0; dec_done = 1'b0;
        check("full_dec_start", 32'(dec_start), 1);
        check("full_dec_data", dec_data, 32'h0000_1230);
        check("full_no_finish_early", 32'(op_done), 0);
        tick();
        check("full_dec_start_once", 32'(dec_start), 0);
        dec_done = 1'b1; dec_data_out = 32'hABCD_1234; dec_num_err = 2'd1;
        tick();
        dec_done = 1'b0;
        check("full_op_done", 32'(op_done), 1);
        tick();

        // Overrun: a write during ENC_WAIT is dropped, op completes normally.
        exp_q.push_back('{data: 32'h89AB_CDEF, nerr: 2'd0});
        launch(2'b00, 32'h1122_3344, 2'b11, 32'h0);
        check("ovr_enc_data_w32", enc_data, 32'h1122_3344);
        tick();
        ctrl_wr = 1'b1; ctrl = 2'b10; data_in = 32'h55;
        tick();
        ctrl_wr = 1'b0;
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_no_restart", 32'(enc_start), 0);
        check("ovr_enc_data_held", enc_data, 32'h1122_3344);
        enc_done = 1'b1; enc_codeword = 32'h89AB_CDEF;
        tick();
        enc_done = 1'b0;
        check("ovr_op_done", 32'(op_done), 1);
        tick();
        check("ovr_no_second_start", 32'(enc_start), 0);
        check("ovr_sticky", 32'(overrun), 1);

        // Reserved opcode: immediate FINISH with uncorrectable status, no launch.
        exp_q.push_back('{data: 32'h0, nerr: 2'd2});
        launch(2'b11, 32'hFFFF_FFFF, 2'b10, 32'h0);
        check("rsvd_op_done", 32'(op_done), 1);
        check("rsvd_busy", 32'(busy), 0);
        check("rsvd_no_enc", 32'(enc_start), 0);
        check("rsvd_overrun_kept", 32'(overrun), 1);
        tick();

        // Decode, 32-bit: launch clears overrun; busy through DEC_WAIT.
        exp_q.push_back('{data: 32'hCAFE_F00D, nerr: 2'd2});
        launch(2'b01, 32'hDEAD_BEEF, 2'b10, 32'h0);
        check("dec_dec_start", 32'(dec_start), 1);
        check("dec_no_enc_start", 32'(enc_start), 0);
        check("dec_dec_data", dec_data, 32'hDEAD_BEEF);
        check("dec_overrun_clr", 32'(overrun), 0);
        check("dec_busy_t1", 32'(busy), 1);
        tick();
        check("dec_busy_t2", 32'(busy), 1);
        tick();
        check("dec_busy_t3", 32'(busy), 1);
        dec_done = 1'b1; dec_data_out = 32'hCAFE_F00D; dec_num_err = 2'd2;
        tick();
        dec_done = 1'b0;
        check("dec_busy_done", 32'(busy), 0);
        check("dec_op_done", 32'(op_done), 1);
        tick(); tick();
        check("dec_data_out_held", data_out, 32'hCAFE_F00D);

        // Reset during DEC_WAIT: everything clears, no op_done.
        launch(2'b01, 32'h0000_01FF, 2'b00, 32'h0);
        check("rstop_dec_data", dec_data, 32'hFF);
        tick();
        rst = 1'b0;
        dec_done = 1'b1; dec_data_out = 32'h1234_5678; dec_num_err = 2'd1;
        tick();
        check("rstop_busy", 32'(busy), 0);
        check("rstop_data_out", data_out, 0);
        check("rstop_num_err", 32'(num_of_errors), 0);
        check("rstop_dec_data_clr", dec_data, 0);
        check("rstop_op_done", 32'(op_done), 0);
        dec_done = 1'b0;
        rst = 1'b1;
        tick();
        check("rstop_idle_op_done", 32'(op_done), 0);

        // Fresh encode after reset, 16-bit.
        exp_q.push_back('{data: 32'h0000_BEEF, nerr: 2'd0});
        launch(2'b00, 32'h0000_BEEF, 2'b01, 32'h0);
        check("post_enc_start", 32'(enc_start), 1);
        tick();
        enc_done = 1'b1; enc_codeword = 32'h0005_BEEF;
        tick();
        enc_done = 1'b0;
        check("post_op_done", 32'(op_done), 1);
        tick();

`ifdef ECC_SEQ_TIMEOUT_EN
        // Silent encoder: FINISH 8 cycles after ENC_WAIT entry.
        exp_q.push_back('{data: 32'h0, nerr: 2'd2});
        launch(2'b00, 32'h0000_0042, 2'b00, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        check("tmo_not_yet", 32'(op_done), 0);
        tick();
        check("tmo_op_done", 32'(op_done), 1);
        check("tmo_flag", 32'(timeout), 1);
        tick();
`endif

        tick(); tick();
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
